// File: rtl/vlan_tag_parser.sv
`default_nettype none
// ============================================================================
// Module   : vlan_tag_parser
// Brief    : Byte-serial Ethernet header walker; strips 802.1Q (and, with
//            VLAN_QINQ_EN defined, an outer 802.1ad) tag and resolves the
//            innermost EtherType for the downstream classifier.
// Revision : 1.0 - initial release
// ============================================================================
module vlan_tag_parser #(
   parameter logic [15:0] TPID_CTAG = 16'h8100,
   parameter logic [15:0] TPID_STAG = 16'h88A8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_sop,
   input  logic        in_last,
   input  logic [7:0]  in_data,
   output logic [15:0] resolved_ethertype,
   output logic        vlan_valid,
   output logic [1:0]  vlan_count,
   output logic [11:0] outer_vid,
   output logic [11:0] inner_vid,
   output logic        hdr_err
);

   localparam logic [2:0] c_idle   = 3'd0;
   localparam logic [2:0] c_mac    = 3'd1;
   localparam logic [2:0] c_et_hi  = 3'd2;
   localparam logic [2:0] c_et_lo  = 3'd3;
   localparam logic [2:0] c_tci_hi = 3'd4;
   localparam logic [2:0] c_tci_lo = 3'd5;
   localparam logic [2:0] c_done   = 3'd6;

   logic [2:0]  r_state;
   logic [3:0]  r_byte_cnt;
   logic [7:0]  r_et_hi;
   logic [3:0]  r_tci_hi;
   logic [1:0]  r_tag_cnt;
   logic [15:0] r_ethertype;
   logic        r_vlan_valid;
   logic [1:0]  r_vlan_count;
   logic [11:0] r_outer_vid;
   logic        r_hdr_err;

   logic [15:0] w_et_value;
   logic        w_is_tpid;

   assign w_et_value = {r_et_hi, in_data};

`ifdef VLAN_QINQ_EN
   logic [11:0] r_inner_vid;

   // First tag may be S-tag or C-tag; a second tag must be a C-tag.
   assign w_is_tpid = (r_tag_cnt == 2'd0) ? ((w_et_value == TPID_CTAG) || (w_et_value == TPID_STAG)) :
                      (r_tag_cnt == 2'd1) ? (w_et_value == TPID_CTAG) : 1'b0;
   assign inner_vid = r_inner_vid;
`else
   assign w_is_tpid = (r_tag_cnt == 2'd0) && (w_et_value == TPID_CTAG);
   assign inner_vid = 12'd0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= c_idle;
         r_byte_cnt   <= 4'd0;
         r_et_hi      <= 8'd0;
         r_tci_hi     <= 4'd0;
         r_tag_cnt    <= 2'd0;
         r_ethertype  <= 16'd0;
         r_vlan_valid <= 1'b0;
         r_vlan_count <= 2'd0;
         r_outer_vid  <= 12'd0;
         r_hdr_err    <= 1'b0;
`ifdef VLAN_QINQ_EN
         r_inner_vid  <= 12'd0;
`endif
      end else begin
         r_hdr_err <= 1'b0;
         if (in_valid) begin
            if (in_sop) begin
               // A sop in any state starts a fresh frame at byte 0.
               r_ethertype  <= 16'd0;
               r_vlan_valid <= 1'b0;
               r_vlan_count <= 2'd0;
               r_outer_vid  <= 12'd0;
`ifdef VLAN_QINQ_EN
               r_inner_vid  <= 12'd0;
`endif
               r_tag_cnt    <= 2'd0;
               r_byte_cnt   <= 4'd1;
               if (in_last) begin
                  r_hdr_err <= 1'b1;
                  r_state   <= c_idle;
               end else begin
                  r_state   <= c_mac;
               end
            end else begin
               case (r_state)
                  c_mac: begin
                     if (in_last) begin
                        r_hdr_err <= 1'b1;
                        r_state   <= c_idle;
                     end else if (r_byte_cnt == 4'd11) begin
                        r_state <= c_et_hi;
                     end else begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                     end
                  end
                  c_et_hi: begin
                     if (in_last) begin
                        r_hdr_err <= 1'b1;
                        r_state   <= c_idle;
                     end else begin
                        r_et_hi <= in_data;
                        r_state <= c_et_lo;
                     end
                  end
                  c_et_lo: begin
                     if (w_is_tpid) begin
                        if (in_last) begin
                           r_hdr_err <= 1'b1;
                           r_state   <= c_idle;
                        end else begin
                           r_tag_cnt <= r_tag_cnt + 2'd1;
                           r_state   <= c_tci_hi;
                        end
                     end else begin
                        r_ethertype  <= w_et_value;
                        r_vlan_count <= r_tag_cnt;
                        r_vlan_valid <= 1'b1;
                        r_state      <= in_last ? c_idle : c_done;
                     end
                  end
                  c_tci_hi: begin
                     if (in_last) begin
                        r_hdr_err <= 1'b1;
                        r_state   <= c_idle;
                     end else begin
                        r_tci_hi <= in_data[3:0];
                        r_state  <= c_tci_lo;
                     end
                  end
                  c_tci_lo: begin
                     if (in_last) begin
                        r_hdr_err <= 1'b1;
                        r_state   <= c_idle;
                     end else begin
`ifdef VLAN_QINQ_EN
                        if (r_tag_cnt == 2'd1)
                           r_outer_vid <= {r_tci_hi, in_data};
                        else
                           r_inner_vid <= {r_tci_hi, in_data};
`else
                        r_outer_vid <= {r_tci_hi, in_data};
`endif
                        r_state <= c_et_hi;
                     end
                  end
                  c_done: begin
                     if (in_last)
                        r_state <= c_idle;
                  end
                  default: r_state <= c_idle;
               endcase
            end
         end
      end
   end

   assign resolved_ethertype = r_ethertype;
   assign vlan_valid         = r_vlan_valid;
   assign vlan_count         = r_vlan_count;
   assign outer_vid          = r_outer_vid;
   assign hdr_err            = r_hdr_err;

endmodule
`default_nettype wire

// File: tb/tb_vlan_tag_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_vlan_tag_parser
// Brief    : Scoreboard bench for vlan_tag_parser (honours VLAN_QINQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vlan_tag_parser;

   typedef logic [7:0] bq_t [$];
   typedef struct packed {
      logic        err;
      logic        vv;
      logic [15:0] et;
      logic [1:0]  cnt;
      logic [11:0] outer;
      logic [11:0] inner;
      logic [7:0]  beat;
   } res_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_sop;
   logic        in_last;
   logic [7:0]  in_data;
   logic [15:0] resolved_ethertype;
   logic        vlan_valid;
   logic [1:0]  vlan_count;
   logic [11:0] outer_vid;
   logic [11:0] inner_vid;
   logic        hdr_err;

   int   checks = 0;
   int   fails  = 0;
   int   drv_idx = 0;
   logic prev_vv = 1'b0;
   res_t exp_q [$];
   res_t obs_q [$];

   vlan_tag_parser dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_sop             (in_sop),
      .in_last            (in_last),
      .in_data            (in_data),
      .resolved_ethertype (resolved_ethertype),
      .vlan_valid         (vlan_valid),
      .vlan_count         (vlan_count),
      .outer_vid          (outer_vid),
      .inner_vid          (inner_vid),
      .hdr_err            (hdr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t mk_ok(input logic [15:0] et, input logic [1:0] cnt,
                                  input logic [11:0] outer, input logic [11:0] inner, input int beat);
      res_t r;
      r.err = 1'b0; r.vv = 1'b1; r.et = et; r.cnt = cnt;
      r.outer = outer; r.inner = inner; r.beat = beat[7:0];
      return r;
   endfunction

   function automatic res_t mk_err(input int beat);
      res_t r;
      r = '0;
      r.err = 1'b1; r.beat = beat[7:0];
      return r;
   endfunction

   // 12 MAC bytes, nhdr header bytes (right-aligned in hdr), then payload.
   function automatic bq_t mk_frame(input logic [127:0] hdr, input int nhdr, input int npay);
      bq_t q;
      for (int i = 0; i < 12; i++) q.push_back(8'h10 + i[7:0]);
      for (int k = 0; k < nhdr; k++) q.push_back(hdr[8*(nhdr-1-k) +: 8]);
      for (int i = 0; i < npay; i++) q.push_back(i == 0 ? 8'h81 : (i == 1 ? 8'h00 : i[7:0]));
      return q;
   endfunction

   // Records a result whenever hdr_err pulses or vlan_valid rises.
   always @(posedge clk) begin : monitor
      int   ci;
      res_t r;
      ci = drv_idx;
      #2;
      if (hdr_err === 1'b1) begin
         r = mk_err(ci);
         r.vv = vlan_valid;
         obs_q.push_back(r);
      end
      if (vlan_valid === 1'b1 && prev_vv !== 1'b1)
         obs_q.push_back(mk_ok(resolved_ethertype, vlan_count, outer_vid, inner_vid, ci));
      prev_vv = vlan_valid;
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drive_beat(input logic sop, input logic last, input logic [7:0] d, input int idx);
      in_valid = 1'b1; in_sop = sop; in_last = last; in_data = d; drv_idx = idx;
      @(posedge clk); #1;
      in_valid = 1'b0; in_sop = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_frame(input bq_t f, input int from, input int to_excl, input int gap_max);
      for (int i = from; i < to_excl; i++) begin
         if (gap_max > 0) idle($urandom_range(gap_max, 0));
         drive_beat(i == 0, i == f.size() - 1, f[i], i);
      end
   endtask

   task automatic collect(output res_t o, output bit got);
      got = 1'b0; o = '0;
      for (int i = 0; i < 64 && obs_q.size() == 0; i++) begin @(posedge clk); #1; end
      if (obs_q.size() != 0) begin o = obs_q.pop_front(); got = 1'b1; end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({resolved_ethertype, vlan_valid, vlan_count, outer_vid, inner_vid, hdr_err} !== 45'd0) begin
         fails++;
         $display("FAIL reset_state: outputs %h, required 0",
                  {resolved_ethertype, vlan_valid, vlan_count, outer_vid, inner_vid, hdr_err});
      end
      rst = 1'b0;
   endtask

   task automatic test_untagged;
      bq_t f; res_t e, o; bit got;
      f = mk_frame(128'h0800, 2, 20);
      exp_q.push_back(mk_ok(16'h0800, 2'd0, 12'h000, 12'h000, 13));
      send_frame(f, 0, f.size(), 0);
      idle(3);
      checks++;
      if ({vlan_valid, resolved_ethertype, vlan_count, outer_vid} !== {1'b1, 16'h0800, 2'd0, 12'h000}) begin
         fails++;
         $display("FAIL untagged_hold: observed %h required %h",
                  {vlan_valid, resolved_ethertype, vlan_count, outer_vid}, {1'b1, 16'h0800, 2'd0, 12'h000});
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); collect(o, got); checks++;
         if (!got || o !== e) begin fails++; $display("FAIL untagged: observed %h expected %h timeout=%0b", o, e, !got); end
      end
      idle(4); checks++;
      if (obs_q.size() != 0) begin fails++; $display("FAIL untagged_extra: observed %0d extra results, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_single_tag;
      bq_t f; res_t e, o; bit got;
      f = mk_frame(128'h8100_0064_86DD, 6, 12);
      exp_q.push_back(mk_ok(16'h86DD, 2'd1, 12'h064, 12'h000, 17));
      send_frame(f, 0, f.size(), 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); collect(o, got); checks++;
         if (!got || o !== e) begin fails++; $display("FAIL single_tag: observed %h expected %h timeout=%0b", o, e, !got); end
      end
      idle(4); checks++;
      if (obs_q.size() != 0) begin fails++; $display("FAIL single_tag_extra: observed %0d extra results, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_qinq;
      bq_t f, g; res_t e, o; bit got;
      f = mk_frame(128'h88A8_000A_8100_0014_0806, 10, 8);
`ifdef VLAN_QINQ_EN
      exp_q.push_back(mk_ok(16'h0806, 2'd2, 12'd10, 12'd20, 21));
      // Third tag exceeds the limit and is reported as the EtherType.
      g = mk_frame(128'h88A8_0005_8100_0007_8100_0009_0800, 14, 4);
      exp_q.push_back(mk_ok(16'h8100, 2'd2, 12'd5, 12'd7, 21));
`else
      exp_q.push_back(mk_ok(16'h88A8, 2'd0, 12'd0, 12'd0, 13));
      g = mk_frame(128'h8100_0005_8100_0007_0800, 10, 4);
      exp_q.push_back(mk_ok(16'h8100, 2'd1, 12'd5, 12'd0, 17));
`endif
      send_frame(f, 0, f.size(), 0);
      send_frame(g, 0, g.size(), 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); collect(o, got); checks++;
         if (!got || o !== e) begin fails++; $display("FAIL qinq: observed %h expected %h timeout=%0b", o, e, !got); end
      end
      idle(4); checks++;
      if (obs_q.size() != 0) begin fails++; $display("FAIL qinq_extra: observed %0d extra results, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_truncation;
      bq_t f; res_t e, o; bit got;
      f = mk_frame(128'h8100_0064, 4, 0);
      exp_q.push_back(mk_err(15));
      send_frame(f, 0, f.size(), 0);
      f = mk_frame(128'h0800, 2, 6);
      exp_q.push_back(mk_ok(16'h0800, 2'd0, 12'd0, 12'd0, 13));
      send_frame(f, 0, f.size(), 0);
      f = mk_frame(128'h0806, 2, 0);
      exp_q.push_back(mk_ok(16'h0806, 2'd0, 12'd0, 12'd0, 13));
      send_frame(f, 0, f.size(), 0);
      f = mk_frame(128'h8100_0123_0800, 6, 3);
      exp_q.push_back(mk_ok(16'h0800, 2'd1, 12'h123, 12'd0, 17));
      send_frame(f, 0, f.size(), 0);
      exp_q.push_back(mk_err(0));
      drive_beat(1'b1, 1'b1, 8'h55, 0);
      exp_q.push_back(mk_err(5));
      for (int i = 0; i < 6; i++) drive_beat(i == 0, i == 5, i[7:0], i);
      f = mk_frame(128'h8100, 2, 0);
      exp_q.push_back(mk_err(13));
      send_frame(f, 0, f.size(), 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); collect(o, got); checks++;
         if (!got || o !== e) begin fails++; $display("FAIL truncation: observed %h expected %h timeout=%0b", o, e, !got); end
      end
      idle(4); checks++;
      if (obs_q.size() != 0) begin fails++; $display("FAIL truncation_extra: observed %0d extra results, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_back_to_back;
      bq_t a, b; res_t e, o; bit got;
      a = mk_frame(128'h0800, 2, 20);
      b = mk_frame(128'h8100_0FFF_86DD, 6, 10);
      for (int run = 0; run < 2; run++) begin
         exp_q.push_back(mk_ok(16'h0800, 2'd0, 12'd0, 12'd0, 13));
         exp_q.push_back(mk_ok(16'h86DD, 2'd1, 12'hFFF, 12'd0, 17));
         send_frame(a, 0, a.size(), run * 3);
         if (run != 0) idle($urandom_range(3, 0));
         drive_beat(1'b1, 1'b0, b[0], 0);
         checks++;
         if (vlan_valid !== 1'b0 || resolved_ethertype !== 16'h0000) begin
            fails++;
            $display("FAIL b2b_clear_run%0d: vlan_valid=%b et=%h, required 0/0000", run, vlan_valid, resolved_ethertype);
         end
         send_frame(b, 1, b.size(), run * 3);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); collect(o, got); checks++;
            if (!got || o !== e) begin fails++; $display("FAIL b2b_run%0d: observed %h expected %h timeout=%0b", run, o, e, !got); end
         end
      end
      idle(4); checks++;
      if (obs_q.size() != 0) begin fails++; $display("FAIL b2b_extra: observed %0d extra results, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_restart;
      bq_t f1, f2; res_t e, o; bit got;
      f1 = mk_frame(128'h86DD, 2, 10);
      f2 = mk_frame(128'h0800, 2, 10);
      exp_q.push_back(mk_ok(16'h0800, 2'd0, 12'd0, 12'd0, 13));
      send_frame(f1, 0, 9, 0);
      send_frame(f2, 0, f2.size(), 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); collect(o, got); checks++;
         if (!got || o !== e) begin fails++; $display("FAIL restart: observed %h expected %h timeout=%0b", o, e, !got); end
      end
      idle(4); checks++;
      if (obs_q.size() != 0) begin fails++; $display("FAIL restart_extra: observed %0d extra results, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_reset_mid;
      bq_t f; res_t e, o; bit got;
      f = mk_frame(128'h8100_0321_0806, 6, 6);
      exp_q.push_back(mk_ok(16'h0806, 2'd1, 12'h321, 12'd0, 17));
      send_frame(f, 0, f.size(), 0);
      e = exp_q.pop_front(); collect(o, got); checks++;
      if (!got || o !== e) begin fails++; $display("FAIL reset_pre: observed %h expected %h timeout=%0b", o, e, !got); end
      #3 rst = 1'b1;
      #1 checks++;
      if ({resolved_ethertype, vlan_valid, vlan_count, outer_vid, inner_vid, hdr_err} !== 45'd0) begin
         fails++;
         $display("FAIL reset_async: outputs %h, required 0",
                  {resolved_ethertype, vlan_valid, vlan_count, outer_vid, inner_vid, hdr_err});
      end
      @(posedge clk); #1 rst = 1'b0;
      send_frame(f, 0, 5, 0);
      in_valid = 1'b1; in_data = f[5]; drv_idx = 5;
      #3 rst = 1'b1;
      #1 checks++;
      if ({resolved_ethertype, vlan_valid, vlan_count, outer_vid, inner_vid, hdr_err} !== 45'd0) begin
         fails++;
         $display("FAIL reset_byte5: outputs %h, required 0",
                  {resolved_ethertype, vlan_valid, vlan_count, outer_vid, inner_vid, hdr_err});
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      // Remaining bytes carry no sop, so an idle parser must ignore them.
      send_frame(f, 6, f.size(), 0);
      f = mk_frame(128'h0800, 2, 4);
      exp_q.push_back(mk_ok(16'h0800, 2'd0, 12'd0, 12'd0, 13));
      send_frame(f, 0, f.size(), 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); collect(o, got); checks++;
         if (!got || o !== e) begin fails++; $display("FAIL reset_post: observed %h expected %h timeout=%0b", o, e, !got); end
      end
      idle(4); checks++;
      if (obs_q.size() != 0) begin fails++; $display("FAIL reset_extra: observed %0d extra results, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_last = 1'b0; in_data = 8'h00;
      test_reset();
      test_untagged();
      test_single_tag();
      test_qinq();
      test_truncation();
      test_back_to_back();
      test_restart();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
